// File: rtl/aes_pkg.sv
// Shared AES primitives and constants for key_expander and cipher.
// The S-box is computed as GF(2^8) inverse (x^254) followed by the affine map.
package aes_pkg;
  localparam int NK128 = 4;
  localparam int NK192 = 6;
  localparam int NK256 = 8;
  localparam int NR128 = 10;
  localparam int NR192 = 12;
  localparam int NR256 = 14;
  localparam int KEY_BITS  = 1920;
  localparam int MAX_WORDS = 60;

  typedef enum logic {IDLE, EXPAND} ke_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^(2+4+...+128); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    inv = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/key_expander_if.sv
// Request/schedule bundle between the key source, key_expander and cipher.
interface key_expander_if;
  logic                          start;
  logic [3:0]                    NK;
  logic [255:0]                  i_key;
  logic [aes_pkg::KEY_BITS-1:0]  expanded_key;
  logic [3:0]                    NR;
  logic                          busy;
  logic                          done;
  logic                          valid;

  modport master (output start, NK, i_key,
                  input  expanded_key, NR, busy, done, valid);
  modport slave  (input  start, NK, i_key,
                  output expanded_key, NR, busy, done, valid);
endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel combinational S-box lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
  end
endmodule

// File: rtl/key_expander.sv
// AES key schedule, one word per clock. KEY_EXP_WIDE_KEY_EN enables AES-192/256;
// without it the block is AES-128 only and NK is ignored.
module key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  key_expander_if.slave kif
);
`ifdef KEY_EXP_WIDE_KEY_EN
  localparam int WIN_W = 8;
  localparam int PH_W  = 3;
  localparam int MAX_W = MAX_WORDS;
`else
  localparam int WIN_W = 4;
  localparam int PH_W  = 2;
  localparam int MAX_W = 44;
`endif

  ke_state_e                   state_q, state_d;
  logic [KEY_BITS-1:0]         ek_q, ek_d;
  logic [3:0]                  nr_q, nr_d;
  logic                        done_q, done_d, valid_q, valid_d;
  logic [5:0]                  i_q, i_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic [7:0]                  rcon_q, rcon_d;
  logic [WIN_W-1:0][31:0]      win_q, win_d;   // win[0] = w[i-1]

  logic [3:0]  nk_in;
  logic        start_ok;
  logic [5:0]  last_idx;
  logic [31:0] sub_in, sub_out, temp, old_w, new_w;

`ifdef KEY_EXP_WIDE_KEY_EN
  logic [3:0] nk_q, nk_d;
  assign nk_in    = kif.NK;
  assign start_ok = kif.start && (kif.NK == 4'd4 || kif.NK == 4'd6 || kif.NK == 4'd8);
`else
  logic unused_ins;
  assign unused_ins = ^{kif.NK, kif.i_key[127:0]};
  assign nk_in    = 4'(NK128);
  assign start_ok = kif.start;
`endif

  assign last_idx = {nr_q + 4'd1, 2'b00} - 6'd1;
  assign sub_in   = (phase_q == '0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  aes_sub_word u_sub (.word_i(sub_in), .word_o(sub_out));

  always_comb begin
    temp  = win_q[0];
    old_w = win_q[3];
    if (phase_q == '0) temp = sub_out ^ {rcon_q, 24'h0};
`ifdef KEY_EXP_WIDE_KEY_EN
    else if (nk_q == 4'd8 && phase_q == 3'd4) temp = sub_out;
    case (nk_q)
      4'd6:    old_w = win_q[5];
      4'd8:    old_w = win_q[7];
      default: old_w = win_q[3];
    endcase
`endif
    new_w = old_w ^ temp;
  end

  always_comb begin
    state_d = state_q;
    ek_d    = ek_q;
    nr_d    = nr_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    i_d     = i_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
`ifdef KEY_EXP_WIDE_KEY_EN
    nk_d    = nk_q;
`endif
    case (state_q)
      IDLE: if (start_ok) begin
`ifdef KEY_EXP_WIDE_KEY_EN
        nk_d = nk_in;
        nr_d = nk_in + 4'd6;
`else
        nr_d = 4'(NR128);
`endif
        ek_d  = '0;
        win_d = '0;
        for (int k = 0; k < WIN_W; k++) begin
          if (k < int'(nk_in)) ek_d[KEY_BITS-1-32*k -: 32] = kif.i_key[255-32*k -: 32];
          // window is newest-first, so key word k lands at slot nk-1-k
          for (int j = 0; j < WIN_W; j++)
            if (int'(nk_in) - 1 - j == k) win_d[j] = kif.i_key[255-32*k -: 32];
        end
        i_d     = 6'(nk_in);
        phase_d = '0;
        rcon_d  = 8'h01;
        valid_d = 1'b0;
        state_d = EXPAND;
      end
      EXPAND: begin
        for (int k = 0; k < MAX_W; k++)
          if (i_q == 6'(k)) ek_d[KEY_BITS-1-32*k -: 32] = new_w;
        win_d = {win_q[WIN_W-2:0], new_w};
        i_d   = i_q + 6'd1;
        if (phase_q == '0) rcon_d = xtime(rcon_q);
`ifdef KEY_EXP_WIDE_KEY_EN
        phase_d = (phase_q == 3'(nk_q - 4'd1)) ? 3'd0 : phase_q + 3'd1;
`else
        phase_d = phase_q + 2'd1;
`endif
        if (i_q == last_idx) begin
          state_d = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ek_q    <= '0;
      nr_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      i_q     <= '0;
      phase_q <= '0;
      rcon_q  <= '0;
      win_q   <= '0;
`ifdef KEY_EXP_WIDE_KEY_EN
      nk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ek_q    <= ek_d;
      nr_q    <= nr_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      win_q   <= win_d;
`ifdef KEY_EXP_WIDE_KEY_EN
      nk_q    <= nk_d;
`endif
    end
  end

  assign kif.expanded_key = ek_q;
  assign kif.NR           = nr_q;
  assign kif.busy         = (state_q == EXPAND);
  assign kif.done         = done_q;
  assign kif.valid        = valid_q;
endmodule

// File: tb/tb_key_expander.sv
// Directed + randomized bench for key_expander against a FIPS-197 array model.
module tb_key_expander;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_expander_if kif ();
  key_expander dut (.clk(clk), .rst(rst), .kif(kif));

  int checks = 0;
  int errors = 0;
  logic [7:0]  sb [256];
  logic [31:0] exp_w [60];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) prod ^= (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (prod[k]) prod ^= (16'h11b << (k - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int k = 0; k < 8; k++)
        s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model(input int nk, input logic [255:0] key);
    int total;
    logic [7:0] rc;
    logic [31:0] t;
    total = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) exp_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) t = subw(t);
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [31:0] dut_w(input int i);
    return kif.expanded_key[1919-32*i -: 32];
  endfunction

  task automatic chk_words(input string tag);
    for (int i = 0; i < 60; i++) chk($sformatf("%s_w%0d", tag, i), 64'(dut_w(i)), 64'(exp_w[i]));
  endtask

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic int rnd_nk();
`ifdef KEY_EXP_WIDE_KEY_EN
    return 4 + 2 * int'($urandom_range(0, 2));
`else
    return 4;
`endif
  endfunction

  // Entered #1 after an edge with the DUT able to accept; leaves in the done cycle.
  task automatic run(input string tag, input int nk, input logic [255:0] key,
                     input int inj_edge, input logic [255:0] inj_key);
    int n, nk_eff;
`ifdef KEY_EXP_WIDE_KEY_EN
    nk_eff = nk;
`else
    nk_eff = 4;
`endif
    model(nk_eff, key);
    kif.start = 1'b1; kif.NK = 4'(nk); kif.i_key = key;
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk({tag, "_busy_e0"},  64'(kif.busy), 64'd1);
    chk({tag, "_valid_e0"}, 64'(kif.valid), 64'd0);
    chk({tag, "_nr_e0"},    64'(kif.NR), 64'(nk_eff + 6));
    n = 0;
    while (kif.done !== 1'b1 && n < 100) begin
      if (n == inj_edge - 1) begin kif.start = 1'b1; kif.i_key = inj_key; kif.NK = 4'(nk); end
      @(posedge clk); n++; #1;
      kif.start = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'(4 * (nk_eff + 7) - nk_eff));
    chk({tag, "_valid"},   64'(kif.valid), 64'd1);
    chk({tag, "_busy_end"}, 64'(kif.busy), 64'd0);
    chk({tag, "_nr"},      64'(kif.NR), 64'(nk_eff + 6));
    chk_words(tag);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(kif.done), 64'd0);
    chk({tag, "_valid_hold"}, 64'(kif.valid), 64'd1);
  endtask

  initial begin
    logic [255:0] k;
    build_sbox();
    rst = 1'b1; kif.start = 1'b0; kif.NK = 4'd4; kif.i_key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ek",    64'(|kif.expanded_key), 64'd0);
    chk("rst_nr",    64'(kif.NR), 64'd0);
    chk("rst_busy",  64'(kif.busy), 64'd0);
    chk("rst_done",  64'(kif.done), 64'd0);
    chk("rst_valid", 64'(kif.valid), 64'd0);
    rst = 1'b0;

    run("aes128", 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, '0);
    chk("aes128_w4",  64'(dut_w(4)),  64'h a0fafe17);
    chk("aes128_w43", 64'(dut_w(43)), 64'h b6630ca6);
    chk("aes128_tail0", 64'(|kif.expanded_key[479:0]), 64'd0);
    pulse_end("aes128");

`ifdef KEY_EXP_WIDE_KEY_EN
    run("aes192", 6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, '0);
    chk("aes192_w6",  64'(dut_w(6)),  64'h fe0c91f7);
    chk("aes192_w51", 64'(dut_w(51)), 64'h 01002202);
    pulse_end("aes192");

    run("aes256_inj", 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
        10, rnd_key());
    chk("aes256_w8",  64'(dut_w(8)),  64'h a573c29f);
    chk("aes256_w56", 64'(dut_w(56)), 64'h 24fc79cc);
    chk("aes256_w57", 64'(dut_w(57)), 64'h bf0979e9);
    chk("aes256_w58", 64'(dut_w(58)), 64'h 371ac23c);
    chk("aes256_w59", 64'(dut_w(59)), 64'h 6d68de36);
    pulse_end("aes256");

    kif.start = 1'b1; kif.NK = 4'd5; kif.i_key = rnd_key();
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk("nk5_busy",  64'(kif.busy), 64'd0);
    chk("nk5_valid", 64'(kif.valid), 64'd1);
    chk("nk5_nr",    64'(kif.NR), 64'd14);
    chk_words("nk5_hold");
`else
    run("nk5_as128", 5, rnd_key(), 0, '0);
    pulse_end("nk5_as128");
`endif

    kif.start = 1'b1; kif.NK = 4'(rnd_nk()); kif.i_key = rnd_key();
    @(posedge clk); #1;
    kif.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ek",    64'(|kif.expanded_key), 64'd0);
    chk("midrst_nr",    64'(kif.NR), 64'd0);
    chk("midrst_busy",  64'(kif.busy), 64'd0);
    chk("midrst_done",  64'(kif.done), 64'd0);
    chk("midrst_valid", 64'(kif.valid), 64'd0);
    rst = 1'b0;
    run("after_rst", rnd_nk(), rnd_key(), 0, '0);
    pulse_end("after_rst");

    run("b2b_a", rnd_nk(), rnd_key(), 0, '0);
    run("b2b_b", rnd_nk(), rnd_key(), 0, '0);
    pulse_end("b2b_b");

    for (int r = 0; r < 3; r++) begin
      k = rnd_key();
      run($sformatf("rnd%0d", r), rnd_nk(), k, 0, '0);
      pulse_end($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
